// File: rtl/vend_pkg.sv
// vend_pkg: shared state/coin encodings and coin values for the vending sequencer
package vend_pkg;
    typedef enum logic [2:0] {S_IDLE, S_VEND, S_LOAD, S_DISPENSE, S_DONE} state_t;
    typedef enum logic [1:0] {COIN_NONE = 2'd0, COIN_Q = 2'd1, COIN_D = 2'd2, COIN_N = 2'd3} coin_t;
    localparam logic [6:0] Q_VAL = 7'd25;
    localparam logic [6:0] D_VAL = 7'd10;
    localparam logic [6:0] N_VAL = 7'd5;
endpackage

// File: rtl/change_picker.sv
// change_picker: greedy choice of the next coin to return from the remaining amount
module change_picker
    import vend_pkg::*;
(
    input  logic [6:0] rem,
    output coin_t      coin,
    output logic [6:0] val
);
    assign coin = rem >= Q_VAL ? COIN_Q : rem >= D_VAL ? COIN_D : rem >= N_VAL ? COIN_N : COIN_NONE;
    assign val  = coin == COIN_Q ? Q_VAL : coin == COIN_D ? D_VAL : coin == COIN_N ? N_VAL : 7'd0;
endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: buy/refund arbitration FSM with greedy coin-change dispensing
module vend_sequencer
    import vend_pkg::*;
#(
    parameter logic [6:0] PRICE0 = 7'd25,
    parameter logic [6:0] PRICE1 = 7'd50,
    parameter logic [6:0] PRICE2 = 7'd75,
    parameter logic [6:0] PRICE3 = 7'd100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] buy,
    input  logic       refund,
    input  logic [6:0] credit,
    input  logic       disp_ready,
    output logic [3:0] vending,
    output logic [6:0] debit,
    output logic       debit_valid,
    output logic       coin_req,
    output logic [1:0] coin_sel,
    output logic [3:0] qcount,
    output logic [3:0] dcount,
    output logic [3:0] ncount,
    output logic       clear_credit,
    output logic       deny,
    output logic       busy
);
    state_t     state, state_nx;
    coin_t      coin;
    logic [6:0] rem, coin_val, price, sel_price;
    logic [3:0] sel;
    logic       onehot, accept, xfer;

    change_picker u_picker (.rem(rem), .coin(coin), .val(coin_val));

    assign price  = buy[0] ? PRICE0 : buy[1] ? PRICE1 : buy[2] ? PRICE2 : PRICE3;
    assign onehot = $onehot(buy);
    assign accept = state == S_IDLE && !refund && onehot && credit >= price;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     state_nx = refund ? S_LOAD : accept ? S_VEND : S_IDLE;
            S_VEND:     state_nx = S_IDLE;
            S_LOAD:     state_nx = S_DISPENSE;
            S_DISPENSE: state_nx = coin == COIN_NONE ? S_DONE : S_DISPENSE;
            default:    state_nx = S_IDLE;
        endcase
    end

    assign vending      = state == S_VEND ? sel : 4'd0;
    assign debit        = state == S_VEND ? sel_price : 7'd0;
    assign debit_valid  = state == S_VEND;
    assign coin_req     = state == S_DISPENSE && coin != COIN_NONE;
    assign coin_sel     = coin_req ? coin : COIN_NONE;
    assign clear_credit = state == S_DONE;
    assign busy         = state != S_IDLE;
    assign xfer         = coin_req && disp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sel       <= '0;
            sel_price <= '0;
            rem       <= '0;
            qcount    <= '0;
            dcount    <= '0;
            ncount    <= '0;
            deny      <= 1'b0;
        end else begin
            state <= state_nx;
            deny  <= state == S_IDLE && !refund && buy != 4'd0 && !accept;
            if (accept) begin
                sel       <= buy;
                sel_price <= price;
            end
            if (state == S_LOAD) begin
                rem    <= credit;
                qcount <= '0;
                dcount <= '0;
                ncount <= '0;
            end
            if (xfer) begin
                rem    <= rem - coin_val;
                qcount <= qcount + {3'd0, coin == COIN_Q && qcount != 4'hf};
                dcount <= dcount + {3'd0, coin == COIN_D && dcount != 4'hf};
                ncount <= ncount + {3'd0, coin == COIN_N && ncount != 4'hf};
            end
            // sub-nickel residue cannot be returned and is dropped with the credit
            if (state == S_DONE) rem <= '0;
        end
    end
endmodule
